// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM states, RV funct3 encodings,
// response error codes and size-to-mask helpers.
package lsu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  // Low offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the word-indexed data memory port.
// slave is the load/store unit's view; master is the core/memory side.
interface lsu_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [63:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [1:0]            resp_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_err, load_data,
    output mem_addr, mem_write_data, mem_write, mem_read
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_err, load_data,
    input  mem_addr, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte lane logic: load extract with sign/zero extension and
// sub-word store merge of new bytes into the old memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] rd_word,
  input  logic [63:0] old_word,
  input  logic [63:0] wdata,
  output logic [63:0] load_ext,
  output logic [63:0] merged
);

  logic [63:0] shifted;
  logic [63:0] wshift;
  logic [7:0]  ben;
  logic        sgn;

  always_comb begin
    shifted  = rd_word >> {offset, 3'b000};
    sgn      = 1'b0;
    load_ext = shifted;
    case (funct3[1:0])
      2'd0: begin
        sgn      = ~funct3[2] & shifted[7];
        load_ext = {{56{sgn}}, shifted[7:0]};
      end
      2'd1: begin
        sgn      = ~funct3[2] & shifted[15];
        load_ext = {{48{sgn}}, shifted[15:0]};
      end
      2'd2: begin
        sgn      = ~funct3[2] & shifted[31];
        load_ext = {{32{sgn}}, shifted[31:0]};
      end
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    wshift = wdata << {offset, 3'b000};
    ben    = byte_mask(funct3[1:0]) << offset;
    merged = old_word;
    for (int i = 0; i < 8; i++) begin
      if (ben[i]) merged[8*i +: 8] = wshift[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: byte-addressed requests to word-indexed memory, RMW for sub-word stores.
// Latency accept->resp_valid: error 1, load/SD 2, SB/SH/SW 3; req_ready only in IDLE, no resp backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  logic [1:0]            state;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [2:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] load_q;
  logic [1:0]            err_q;

  logic       in_illegal;
  logic       in_misalign;
  logic       in_range_err;
  logic [1:0] in_err;
  logic [63:0] load_ext;
  logic [63:0] merged;

  always_comb begin
    in_illegal   = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    in_misalign  = |(bus.req_addr[2:0] & align_mask(bus.req_funct3[1:0]));
    in_range_err = |bus.req_addr[63:ADDR_WIDTH+3];
    in_err       = ERR_OK;
    if (in_illegal)        in_err = ERR_ILLEGAL;
    else if (in_misalign)  in_err = ERR_MISALIGN;
    else if (in_range_err) in_err = ERR_RANGE;
  end

  lsu_align u_align (
    .funct3   (r_funct3),
    .offset   (r_off),
    .rd_word  (bus.mem_read_data),
    .old_word (merge_q),
    .wdata    (r_wdata),
    .load_ext (load_ext),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 3'b000;
      r_idx    <= '0;
      r_wdata  <= '0;
      merge_q  <= '0;
      load_q   <= '0;
      err_q    <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_store  <= bus.req_store;
            r_funct3 <= bus.req_funct3;
            r_off    <= bus.req_addr[2:0];
            r_idx    <= bus.req_addr[ADDR_WIDTH+2:3];
            r_wdata  <= bus.req_wdata;
            err_q    <= in_err;
            if (in_err != ERR_OK)
              state <= ST_RESP;
            else if (bus.req_store && (bus.req_funct3[1:0] == 2'd3))
              state <= ST_WRITE;
            else
              state <= ST_READ;
          end
        end
        ST_READ: begin
          // Sub-word stores park the old word for the merge; loads finish here.
          if (r_store) begin
            merge_q <= bus.mem_read_data;
            state   <= ST_WRITE;
          end else begin
            load_q <= load_ext;
            state  <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready      = (state == ST_IDLE);
    bus.resp_valid     = (state == ST_RESP);
    bus.resp_err       = (state == ST_RESP) ? err_q : ERR_OK;
    bus.load_data      = load_q;
    bus.mem_read       = (state == ST_READ);
    bus.mem_write      = (state == ST_WRITE);
    bus.mem_addr       = r_idx;
    bus.mem_write_data = (r_funct3[1:0] == 2'd3) ? r_wdata : merged;
  end

endmodule
